// File: rtl/bcd_display_scan_pkg.sv
// Shared types and constants for the BCD display scanner: 7-segment patterns
// (active-low, {g,f,e,d,c,b,a}) and the scan state encoding.
package bcd_disp_pkg;

  typedef logic [6:0] seg7_t;

  localparam int DIGITS = 4;

  localparam seg7_t SEG_BLANK = 7'b1111111;
  localparam seg7_t SEG_DASH  = 7'b0111111;

  localparam seg7_t DIGIT_PAT [10] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  // Encoding equals the digit index, so the state doubles as the nibble select.
  typedef enum logic [1:0] {
    S_D0 = 2'd0,
    S_D1 = 2'd1,
    S_D2 = 2'd2,
    S_D3 = 2'd3
  } scan_state_t;

endpackage

// File: rtl/bcd_display_scan_if.sv
// Converter-to-display bus: BCD word with load strobe in, multiplexed display drive out.
// Handshake: bcd_valid is a one-cycle load strobe with no ready; bcd_in is taken on every edge where bcd_valid=1.
interface bcd_display_scan_if;
  import bcd_disp_pkg::*;

  logic [15:0] bcd_in;
  logic        bcd_valid;
  logic [3:0]  anodo;
  seg7_t       segmentos;
  logic        err_bcd;
  logic        frame_done;
  scan_state_t dbg_state;

  modport master (
    output bcd_in, bcd_valid,
    input  anodo, segmentos, err_bcd, frame_done, dbg_state
  );

  modport slave (
    input  bcd_in, bcd_valid,
    output anodo, segmentos, err_bcd, frame_done, dbg_state
  );

endinterface

// File: rtl/bcd_display_scan_bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment pattern; non-decimal nibbles show a dash.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG_DASH;
    if (nibble <= 4'd9) seg = DIGIT_PAT[nibble];
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Latches a 4-digit packed BCD word and scans it onto a common-anode 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (units always shown).
module bcd_display_scan
  import bcd_disp_pkg::*;
#(
  parameter int PRESC_DIV  = 50000,
  parameter bit SEG_ACT_LO = 1'b1
) (
  input logic clk,
  input logic rst,
  bcd_display_scan_if.slave bus
);

  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);
  localparam logic [3:0] AN_OFF  = SEG_ACT_LO ? 4'b1111 : 4'b0000;
  localparam seg7_t      SEG_OFF = SEG_ACT_LO ? SEG_BLANK : ~SEG_BLANK;

  logic [PW-1:0] presc;
  logic          tick;
  logic [15:0]   shadow;
  scan_state_t   state, state_nxt;
  logic [1:0]    idx;
  logic [3:0]    nib;
  seg7_t         seg_dec, seg_lo;
  logic [3:0]    an_lo;
  logic          blank;
  logic          err_nxt;
  logic [3:0]    anodo_q;
  seg7_t         seg_q;
  logic          err_q, frame_q;

  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (rst || tick) presc <= '0;
    else             presc <= presc + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                shadow <= 16'h0000;
    else if (bus.bcd_valid) shadow <= bus.bcd_in;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_D0;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        S_D0:    state_nxt = S_D1;
        S_D1:    state_nxt = S_D2;
        S_D2:    state_nxt = S_D3;
        default: state_nxt = S_D0;
      endcase
    end
  end

  assign idx = state;
  assign nib = shadow[{idx, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .nibble (nib),
    .seg    (seg_dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Digit i is blank when nibbles i..3 are all zero; units excluded.
  logic [3:0] lz;
  always_comb begin
    lz    = '0;
    lz[3] = (shadow[15:12] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--)
      lz[i] = lz[i+1] && (shadow[i*4 +: 4] == 4'd0);
    blank = (idx != 2'd0) && lz[idx];
  end
`else
  assign blank = 1'b0;
`endif

  assign seg_lo = blank ? SEG_BLANK : seg_dec;
  assign an_lo  = ~(4'b0001 << idx);

  always_comb begin
    err_nxt = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (shadow[i*4 +: 4] > 4'd9) err_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      anodo_q <= AN_OFF;
      seg_q   <= SEG_OFF;
      err_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      anodo_q <= SEG_ACT_LO ? an_lo  : ~an_lo;
      seg_q   <= SEG_ACT_LO ? seg_lo : ~seg_lo;
      err_q   <= err_nxt;
      frame_q <= tick && (state == S_D3);
    end
  end

  assign bus.anodo      = anodo_q;
  assign bus.segmentos  = seg_q;
  assign bus.err_bcd    = err_q;
  assign bus.frame_done = frame_q;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan: a PRESC_DIV=4 instance for the main checks and a
// PRESC_DIV=1 instance for the every-cycle scan case.
module tb_bcd_display_scan;
  import bcd_disp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_display_scan_if bus  ();
  bcd_display_scan_if bus1 ();

  bcd_display_scan #(.PRESC_DIV(4), .SEG_ACT_LO(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bcd_display_scan #(.PRESC_DIV(1), .SEG_ACT_LO(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [6:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: pat = 7'b1000000;
      1: pat = 7'b1111001;
      2: pat = 7'b0100100;
      3: pat = 7'b0110000;
      4: pat = 7'b0011001;
      5: pat = 7'b0010010;
      6: pat = 7'b0000010;
      7: pat = 7'b1111000;
      8: pat = 7'b0000000;
      9: pat = 7'b0010000;
      default: pat = 7'b0111111;
    endcase
  endfunction

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] one;
    one   = 4'b0001;
    an_of = ~(one << d);
  endfunction

  task automatic wait_digit(input int d);
    int k;
    k = 0;
    while (bus.anodo !== an_of(d) && k < 40) begin
      step(1);
      k++;
    end
    if (k >= 40) check("wait_digit_timeout", {28'd0, bus.anodo}, {28'd0, an_of(d)});
  endtask

  task automatic load(input logic [15:0] v);
    bus.bcd_in    = v;
    bus.bcd_valid = 1'b1;
    step(1);
    bus.bcd_valid = 1'b0;
  endtask

  initial begin
    int f1, f2, kd, a0, k;
    int dig1234 [4];
    dig1234 = '{4, 3, 2, 1};

    rst            = 1'b1;
    bus.bcd_in     = 16'h0000;
    bus.bcd_valid  = 1'b0;
    bus1.bcd_in    = 16'h0000;
    bus1.bcd_valid = 1'b0;

    // Reset state and first frame timing.
    step(3);
    check("rst_anodo", {28'd0, bus.anodo}, 32'hF);
    check("rst_seg", {25'd0, bus.segmentos}, 32'h7F);
    check("rst_err", {31'd0, bus.err_bcd}, 32'd0);
    check("rst_fd", {31'd0, bus.frame_done}, 32'd0);
    rst = 1'b0;
    cyc = 0;
    step(1);
    check("first_anodo", {28'd0, bus.anodo}, 32'hE);
    check("first_seg", {25'd0, bus.segmentos}, {25'd0, 7'b1000000});
    check("first_state", {30'd0, bus.dbg_state}, {30'd0, S_D0});
    step(3);
    check("hold_anodo", {28'd0, bus.anodo}, 32'hE);
    step(1);
    check("adv_anodo", {28'd0, bus.anodo}, 32'hD);
    f1 = -1;
    f2 = -1;
    while (cyc < 40) begin
      step(1);
      if (bus.frame_done === 1'b1) begin
        if (f1 < 0) f1 = cyc;
        else if (f2 < 0) f2 = cyc;
      end
    end
    check("fd_first", f1, 16);
    check("fd_second", f2, 32);

    // Load 0012 and scan all four digits.
    load(16'h0012);
    step(1);
    exp_q.push_back(pat(2));
    exp_q.push_back(pat(1));
`ifdef LEADING_ZERO_BLANK_EN
    exp_q.push_back(7'b1111111);
    exp_q.push_back(7'b1111111);
`else
    exp_q.push_back(pat(0));
    exp_q.push_back(pat(0));
`endif
    for (int d = 0; d < 4; d++) begin
      wait_digit(d);
      check($sformatf("t2_digit%0d", d), {25'd0, bus.segmentos}, {25'd0, exp_q.pop_front()});
    end

    // Invalid nibble: dash and error flag, then clear.
    load(16'h9A03);
    check("err_lag", {31'd0, bus.err_bcd}, 32'd0);
    step(1);
    check("err_set", {31'd0, bus.err_bcd}, 32'd1);
    wait_digit(2);
    check("dash", {25'd0, bus.segmentos}, {25'd0, 7'b0111111});
    wait_digit(3);
    check("nine", {25'd0, bus.segmentos}, {25'd0, 7'b0010000});
    wait_digit(0);
    check("three", {25'd0, bus.segmentos}, {25'd0, 7'b0110000});
    load(16'h0010);
    check("err_hold", {31'd0, bus.err_bcd}, 32'd1);
    step(1);
    check("err_clear", {31'd0, bus.err_bcd}, 32'd0);

    // Load coinciding with a tick: locate a digit change, then strobe on the next tick edge.
    a0 = bus.anodo;
    k = 0;
    while (bus.anodo === a0[3:0] && k < 10) begin
      step(1);
      k++;
    end
    check("t4_sync", (k < 10) ? 32'd1 : 32'd0, 32'd1);
    kd = 0;
    for (int d = 0; d < 4; d++) if (bus.anodo === an_of(d)) kd = d;
    step(2);
    bus.bcd_in    = 16'h1234;
    bus.bcd_valid = 1'b1;
    step(1);
    bus.bcd_valid = 1'b0;
    step(1);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) step(4);
      check($sformatf("t4_anodo%0d", j), {28'd0, bus.anodo}, {28'd0, an_of((kd + 1 + j) % 4)});
      check($sformatf("t4_seg%0d", j), {25'd0, bus.segmentos},
            {25'd0, pat(dig1234[(kd + 1 + j) % 4])});
    end

    // Reset mid-frame at digit 2 with a load pending.
    wait_digit(2);
    rst           = 1'b1;
    bus.bcd_in    = 16'hFFFF;
    bus.bcd_valid = 1'b1;
    step(1);
    check("t5_anodo", {28'd0, bus.anodo}, 32'hF);
    check("t5_seg", {25'd0, bus.segmentos}, 32'h7F);
    check("t5_err", {31'd0, bus.err_bcd}, 32'd0);
    check("t5_state", {30'd0, bus.dbg_state}, {30'd0, S_D0});
    rst           = 1'b0;
    bus.bcd_valid = 1'b0;
    step(1);
    check("t5_restart_anodo", {28'd0, bus.anodo}, 32'hE);
    check("t5_restart_seg", {25'd0, bus.segmentos}, {25'd0, 7'b1000000});
    step(1);
    check("t5_err_after", {31'd0, bus.err_bcd}, 32'd0);

    // PRESC_DIV=1 instance: advance every cycle, frame_done every 4th.
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step(1);
      check($sformatf("p1_anodo_c%0d", c), {28'd0, bus1.anodo}, {28'd0, an_of((c - 1) % 4)});
      check($sformatf("p1_fd_c%0d", c), {31'd0, bus1.frame_done}, (c % 4 == 0) ? 32'd1 : 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
